// File: rtl/regfile_writeback_pkg.sv
// Shared sizing constants for the register file and its write-back queue.
package regfile_writeback_pkg;

  localparam int unsigned AddrWidth    = 5;
  localparam int unsigned DataWidth    = 16;
  localparam int unsigned RegDepth     = 32;
  localparam int unsigned WbDepth      = 4;
  localparam int unsigned NumReadPorts = 3;

endpackage

// File: rtl/regfile_writeback_if.sv
// Request and register-file write-port bundle for the write-back block.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned DATA_W = DataWidth
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_en;

  // Request sources and register-file observer.
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready, write_addr, write_data, write_en
  );

  // The write-back block.
  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready, write_addr, write_data, write_en
  );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order write queue with an age-ordered view of every entry (index 0 is the oldest).
module wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [AddrW-1:0]         push_addr_i,
  input  logic [DataW-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [AddrW-1:0]         head_addr_o,
  output logic [DataW-1:0]         head_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [Depth*AddrW-1:0]   ent_addr_o,
  output logic [Depth*DataW-1:0]   ent_data_o,
  output logic [Depth-1:0]         ent_valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [AddrW-1:0] addr_q [Depth];
  logic [DataW-1:0] data_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointer and occupancy next state; pointers wrap naturally at Depth.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  // Pointer and occupancy state; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents outside the valid window are never observed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Rotate storage so consumers see entries oldest-first.
  always_comb begin
    ent_addr_o  = '0;
    ent_data_o  = '0;
    ent_valid_o = '0;
    for (int i = 0; i < Depth; i++) begin
      ent_addr_o[i*AddrW +: AddrW] = addr_q[rd_ptr_q + PtrW'(i)];
      ent_data_o[i*DataW +: DataW] = data_q[rd_ptr_q + PtrW'(i)];
      ent_valid_o[i]               = CntW'(i) < count_q;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back initiator: arbitrates ALU/load writes into a queue, drains one per cycle to the
// register file write port, and reports pending-write hazards with youngest-data forwarding.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH  = WbDepth,
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned DATA_W = DataWidth
) (
  input  logic              clk,
  input  logic              rst,
  regfile_writeback_if.slave bus,
  input  logic [ADDR_W-1:0] read_addr_1_i,
  input  logic [ADDR_W-1:0] read_addr_2_i,
  input  logic [ADDR_W-1:0] read_addr_3_i,
  output logic              busy_1_o,
  output logic              busy_2_o,
  output logic              busy_3_o,
  output logic [DATA_W-1:0] fwd_data_1_o,
  output logic [DATA_W-1:0] fwd_data_2_o,
  output logic [DATA_W-1:0] fwd_data_3_o,
  output logic              idle_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [CntW-1:0]         count;
  logic                    has_room, alu_take, ld_take, push, pop;
  logic [ADDR_W-1:0]       push_addr, head_addr;
  logic [DATA_W-1:0]       push_data, head_data;
  logic [DEPTH*ADDR_W-1:0] ent_addr;
  logic [DEPTH*DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]        ent_valid;

  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Arbitration: ALU wins; readiness looks only at current occupancy, not a same-cycle pop.
  always_comb begin
    has_room  = count < CntW'(DEPTH);
    alu_take  = bus.alu_valid & has_room;
    ld_take   = bus.ld_valid & has_room & ~bus.alu_valid;
    push      = alu_take | ld_take;
    push_addr = alu_take ? bus.alu_addr : bus.ld_addr;
    push_data = alu_take ? bus.alu_data : bus.ld_data;
  end

  assign bus.alu_ready = has_room;
  assign bus.ld_ready  = has_room & ~bus.alu_valid;

  // The output stage drains whenever anything is queued.
  assign pop = (count != '0);

  wb_fifo #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (push_addr),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data),
    .ent_valid_o (ent_valid)
  );

  // Output stage next state: load the head on a pop, otherwise hold address/data.
  always_comb begin
    write_en_d   = pop;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_addr_d = head_addr;
      write_data_d = head_data;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign idle_o         = ~pop & ~write_en_q;

  // Returns {busy, data}. Scan oldest to newest so the youngest match overwrites; the
  // output stage is the oldest pending write and is checked first.
  function automatic logic [DATA_W:0] youngest_match(
    input logic [ADDR_W-1:0]       raddr,
    input logic                    wen,
    input logic [ADDR_W-1:0]       waddr,
    input logic [DATA_W-1:0]       wdata,
    input logic [DEPTH-1:0]        valid,
    input logic [DEPTH*ADDR_W-1:0] addrs,
    input logic [DEPTH*DATA_W-1:0] datas
  );
    logic [DATA_W:0] res;
    res = '0;
    if (wen && waddr == raddr) res = {1'b1, wdata};
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && addrs[i*ADDR_W +: ADDR_W] == raddr) begin
        res = {1'b1, datas[i*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Three identical hazard/forward ports.
  always_comb begin
    {busy_1_o, fwd_data_1_o} = youngest_match(read_addr_1_i, write_en_q, write_addr_q,
                                              write_data_q, ent_valid, ent_addr, ent_data);
    {busy_2_o, fwd_data_2_o} = youngest_match(read_addr_2_i, write_en_q, write_addr_q,
                                              write_data_q, ent_valid, ent_addr, ent_data);
    {busy_3_o, fwd_data_3_o} = youngest_match(read_addr_3_i, write_en_q, write_addr_q,
                                              write_data_q, ent_valid, ent_addr, ent_data);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed plus randomized bench for regfile_writeback with a pending-write list reference model.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int unsigned DEPTH = WbDepth;
  localparam int unsigned AW    = AddrWidth;
  localparam int unsigned DW    = DataWidth;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra   [3];
  logic          busy [3];
  logic [DW-1:0] fwd  [3];
  logic          idle;

  regfile_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_writeback #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .read_addr_1_i (ra[0]),
    .read_addr_2_i (ra[1]),
    .read_addr_3_i (ra[2]),
    .busy_1_o      (busy[0]),
    .busy_2_o      (busy[1]),
    .busy_3_o      (busy[2]),
    .fwd_data_1_o  (fwd[0]),
    .fwd_data_2_o  (fwd[1]),
    .fwd_data_3_o  (fwd[2]),
    .idle_o        (idle)
  );

  always #5 clk = ~clk;

  // Reference: writes accepted but not yet on the port (oldest first), plus the word on the port.
  wr_t           pend [$];
  wr_t           sent [$];
  logic          m_wen;
  wr_t           m_out;
  logic [DW-1:0] dut_regs [RegDepth];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest pending write to an address wins; the word on the port is the oldest.
  task automatic model_hz(input logic [AW-1:0] a, output logic b, output logic [DW-1:0] d);
    b = 1'b0;
    d = '0;
    if (m_wen && m_out.addr == a) begin
      b = 1'b1;
      d = m_out.data;
    end
    foreach (pend[i]) begin
      if (pend[i].addr == a) begin
        b = 1'b1;
        d = pend[i].data;
      end
    end
  endtask

  task automatic check_outputs();
    logic          b;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("write_en", bus.write_en, m_wen);
    chk("write_addr", bus.write_addr, m_out.addr);
    chk("write_data", bus.write_data, m_out.data);
    chk("alu_ready", bus.alu_ready, pend.size() < DEPTH);
    chk("ld_ready", bus.ld_ready, (pend.size() < DEPTH) && !bus.alu_valid);
    chk("idle", idle, (pend.size() == 0) && !m_wen);
    for (int p = 0; p < 3; p++) begin
      model_hz(ra[p], b, d);
      chk($sformatf("busy_%0d", p + 1), busy[p], b);
      chk($sformatf("fwd_data_%0d", p + 1), fwd[p], d);
    end
    if (bus.write_en) begin
      chk("sb_has_pending", sent.size() != 0, 1);
      if (sent.size() != 0) begin
        chk("sb_addr", bus.write_addr, sent[0].addr);
        chk("sb_data", bus.write_data, sent[0].data);
        void'(sent.pop_front());
      end
      dut_regs[bus.write_addr] = bus.write_data;
    end
  endtask

  task automatic edge_update();
    wr_t  acc;
    logic take;
    @(posedge clk);
    take = 1'b0;
    acc  = '0;
    if (pend.size() < DEPTH && bus.alu_valid) begin
      take = 1'b1;
      acc  = '{addr: bus.alu_addr, data: bus.alu_data};
    end else if (pend.size() < DEPTH && bus.ld_valid) begin
      take = 1'b1;
      acc  = '{addr: bus.ld_addr, data: bus.ld_data};
    end
    if (pend.size() != 0) begin
      m_out = pend.pop_front();
      m_wen = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    if (take) begin
      pend.push_back(acc);
      sent.push_back(acc);
    end
    #1;
  endtask

  task automatic cycle();
    check_outputs();
    edge_update();
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ldd;
  endtask

  initial begin
    m_wen = 1'b0;
    m_out = '0;
    foreach (dut_regs[i]) dut_regs[i] = '0;
    for (int p = 0; p < 3; p++) ra[p] = AW'(p);
    drive(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset values.
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write latency: addr 3 / BEEF.
    ra[0] = 3;
    drive(1'b1, 5'd3, 16'hBEEF, 1'b0, '0, '0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("lat_not_yet", bus.write_en, 0);
    cycle();
    chk("lat_wen", bus.write_en, 1);
    chk("lat_addr", bus.write_addr, 3);
    chk("lat_data", bus.write_data, 16'hBEEF);
    cycle();
    chk("lat_one_cycle", bus.write_en, 0);
    cycle();

    // Simultaneous sources: ALU first, then load.
    ra[0] = 1;
    ra[1] = 2;
    drive(1'b1, 5'd1, 16'h1111, 1'b1, 5'd2, 16'h2222);
    cycle();
    drive(1'b0, '0, '0, 1'b1, 5'd2, 16'h2222);
    cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) cycle();
    chk("sim_reg1", dut_regs[1], 16'h1111);
    chk("sim_reg2", dut_regs[2], 16'h2222);

    // Back-to-back ALU stream with a load held off the whole time.
    for (int n = 0; n < DEPTH + 2; n++) begin
      ra[2] = AW'(n + 8);
      drive(1'b1, AW'(n + 8), DW'(16'h100 + n), 1'b1, 5'd30, 16'h3030);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) cycle();

    // Duplicate address forwarding on register 7.
    for (int p = 0; p < 3; p++) ra[p] = 7;
    for (int v = 1; v <= 3; v++) begin
      drive(1'b1, 5'd7, DW'(v), 1'b0, '0, '0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) cycle();
    chk("dup_reg7", dut_regs[7], 3);

    // Random streaming across several pointer wraps.
    for (int n = 0; n < 12 * DEPTH; n++) begin
      drive(1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom),
            1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
      for (int p = 0; p < 3; p++) ra[p] = AW'($urandom_range(7));
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) cycle();
    chk("rand_all_written", sent.size(), 0);

    // Reset mid-operation with writes in flight.
    drive(1'b1, 5'd4, 16'h4444, 1'b0, '0, '0);
    cycle();
    drive(1'b1, 5'd5, 16'h5555, 1'b0, '0, '0);
    cycle();
    ra[0] = 4;
    ra[1] = 5;
    ra[2] = 5;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    chk("rst_wen", bus.write_en, 0);
    chk("rst_addr", bus.write_addr, 0);
    chk("rst_busy1", busy[0], 0);
    chk("rst_busy2", busy[1], 0);
    chk("rst_idle", idle, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    pend.delete();
    sent.delete();
    m_wen = 1'b0;
    m_out = '0;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
